// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ctrl
//  Purpose  : Run-time controller for the programmable divided clock.
//             Divides clk by 2*cur_half with start/stop sequencing and a
//             valid/ready ratio-change port. Ratio changes and stops take
//             effect only at the end of a full period, so every high and
//             low phase lasts exactly cur_half cycles (no runt pulses).
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
  parameter int             W            = 16,
  parameter logic [W-1:0]   DEFAULT_HALF = 16'd54
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_half,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         tick,
  output logic         running,
  output logic [W-1:0] cur_half
);

  localparam logic [W-1:0] c_ONE = W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_count;
  logic         r_clk_out;
  logic         r_tick;
  logic         r_cfg_err;
  logic [W-1:0] r_cur_half;
  logic [W-1:0] r_pend;
  logic         r_pend_vld;

  logic w_active;
  logic w_wrap;
  logic w_bnd;
  logic w_xfer;
  logic w_zero;

  // Phase end, period end (falling toggle) and config transfer decode
  assign w_active = (r_state != ST_IDLE);
  assign w_wrap   = (r_count == (r_cur_half - c_ONE));
  assign w_bnd    = w_active && w_wrap && r_clk_out;
  assign w_xfer   = cfg_valid && !r_pend_vld;
  assign w_zero   = (cfg_half == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: stops only complete at a period boundary
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!en) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (en)         w_state_nxt = ST_RUN;
        else if (w_bnd) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Half-period counter, divided clock and rising-edge tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!w_active) begin
      r_count   <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_wrap) begin
      r_count   <= '0;
      r_clk_out <= ~r_clk_out;
      r_tick    <= ~r_clk_out;
    end else begin
      r_count   <= r_count + c_ONE;
      r_tick    <= 1'b0;
    end
  end

  // Ratio handshake: immediate when idle, deferred to the boundary when running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_err  <= 1'b0;
      r_cur_half <= DEFAULT_HALF;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && w_zero;
      if (!w_active) begin
        // An update captured in the final DRAIN cycle lands here
        if (r_pend_vld) begin
          r_cur_half <= r_pend;
          r_pend_vld <= 1'b0;
        end else if (w_xfer && !w_zero) begin
          r_cur_half <= cfg_half;
        end
      end else if (w_bnd && r_pend_vld) begin
        r_cur_half <= r_pend;
        r_pend_vld <= 1'b0;
      end else if (w_xfer && !w_zero) begin
        r_pend     <= cfg_half;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign cfg_ready = !r_pend_vld;
  assign running   = w_active;
  assign cfg_err   = r_cfg_err;
  assign clk_out   = r_clk_out;
  assign tick      = r_tick;
  assign cur_half  = r_cur_half;

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the programmable divided clock that paces the baseband blocks. Divides the system clock by 2*half (default half 54, matching the fixed 1 kHz-class divider). Adds start/stop sequencing, a valid/ready interface for changing the divide ratio, and guarantees no runt pulses on clk_out. It sits between the control/register logic and every consumer of the slow clock/tick.

Parameters:
W, 16, width of half-period count and config value
DEFAULT_HALF, 16'd54, half-period (in clk cycles) loaded at reset

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  new half-period offered
cfg_half  input  W  requested half-period in clk cycles
cfg_ready  output  1  controller can accept cfg (= no pending update)
cfg_err  output  1  one-cycle pulse: accepted cfg had cfg_half==0, discarded
clk_out  output  1  divided clock, 50% duty, period 2*cur_half
tick  output  1  one-cycle strobe in the first clk cycle clk_out reads 1
running  output  1  state != IDLE
cur_half  output  W  half-period currently in effect

Behaviour:
- Reset (async, reset==0): state=IDLE, count=0, clk_out=0, tick=0, cfg_err=0, cur_half=DEFAULT_HALF, pending cleared (cfg_ready=1). All outputs registered except cfg_ready and running, which decode from registered state.
- FSM states are IDLE, RUN and DRAIN:
  - IDLE -> RUN when en=1. count=0, clk_out=0 on entry.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1 (stop cancelled, no discontinuity).
  - DRAIN -> IDLE at the next boundary.
- Counting (RUN/DRAIN): each cycle, if count==cur_half-1 then count<=0 and clk_out<=~clk_out; else count<=count+1. IDLE holds count=0, clk_out=0.
- tick<=1 exactly when clk_out toggles 0->1, else 0. One tick per period.
- Boundary: the cycle with count==cur_half-1 and clk_out==1 (the falling toggle, i.e. the end of a full period). Ratio changes and stops happen only here, so every high and low phase lasts exactly cur_half cycles.
- Config handshake: transfer when cfg_valid && cfg_ready.
  - cfg_half==0: cfg_err=1 for one cycle; value discarded; no other effect.
  - In IDLE: cur_half<=cfg_half immediately; pending not set.
  - In RUN/DRAIN: value stored in the pending register; cfg_ready=0 until applied. At the next boundary cur_half<=pending, pending cleared, and the new ratio starts with the following low phase.
  - A transfer in the boundary cycle itself is applied at the following boundary, not the current one.
- en rising and a cfg transfer in the same IDLE cycle: the new cur_half is used from the first RUN cycle.
- DRAIN with pending: the update is applied at the same boundary that returns to IDLE.
- Reset mid-operation: clk_out drops to 0 immediately; pending discarded; cur_half=DEFAULT_HALF.
- Arithmetic: count is W bits, unsigned, compared against cur_half-1; cur_half=1 gives clk_out=clk/2 with tick every 2 cycles.

Test Plan:
- Reset, then en=1 held: clk_out alternates 54 cycles low / 54 high (period 108), first rise 54 cycles after RUN entry. tick is 1 cycle wide, once per 108. cur_half=54.
- Mid high phase, transfer cfg_half=10: cfg_ready=0 until the boundary. The current high phase completes at 54 cycles, then 10/10 phases follow, and cur_half reads 10 after the boundary.
- cfg_half=0 offered in RUN: cfg_err pulses exactly 1 cycle, cur_half stays 54, and the clk_out period is unchanged.
- en=0 at cycle 20 of a low phase: low phase completes (54), full 54 high phase follows, then clk_out stays 0 and running drops at the boundary. No phase shorter than 54.
- en=0 then en=1 5 cycles later (within DRAIN): clk_out continues with no gap or phase change, and running stays 1.
- Combined IDLE case: en=1 and cfg_half=3 in the same cycle gives 3/3 phases from the start. reset=0 asserted mid high phase gives clk_out=0 immediately, and after release cur_half=54 and cfg_ready=1.
